// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: 3-cycle fetch followed by per-opcode execute
// steps T3..T7, driving datapath strobes, register-field selects and the ALU select.
module control_unit #(
    parameter logic [4:0]  ADD_SEL       = 5'b00011,
    parameter int unsigned ILLEGAL_HALTS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        run,
    output logic        illegal,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        CONin,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_sel
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // T0..T7 are consecutive so an execute step can advance by increment.
    typedef enum logic [3:0] {
        RESET_ST = 4'd0,
        T0       = 4'd1,
        T1       = 4'd2,
        T2       = 4'd3,
        T3       = 4'd4,
        T4       = 4'd5,
        T5       = 4'd6,
        T6       = 4'd7,
        T7       = 4'd8,
        HALTED   = 4'd9
    } state_t;

    state_t     state;
    logic [4:0] op;
    logic       ir_unused;

    assign op        = ir[31:27];
    assign ir_unused = ^ir[26:0];

    function automatic logic is_known(input logic [4:0] code);
        case (code)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JR, OP_NOP, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic state_t last_step(input logic [4:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: return T5;
            OP_LD, OP_ST:                     return T7;
            OP_BR:                            return T6;
            default:                          return T3;
        endcase
    endfunction

    function automatic logic [4:0] imm_alu(input logic [4:0] code);
        case (code)
            OP_ANDI: return 5'b00101;
            OP_ORI:  return 5'b00110;
            default: return 5'b00011;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RESET_ST;
            illegal <= 1'b0;
        end else begin
            case (state)
                RESET_ST: state <= stop ? HALTED : T0;
                T0:       state <= T1;
                T1:       state <= T2;
                T2:       state <= T3;
                T3: begin
                    if (op == OP_HALT) begin
                        state <= HALTED;
                    end else if (!is_known(op) && ILLEGAL_HALTS != 0) begin
                        illegal <= 1'b1;
                        state   <= HALTED;
                    end else if (last_step(op) == T3) begin
                        state <= stop ? HALTED : T0;
                    end else begin
                        state <= T4;
                    end
                end
                T4, T5, T6, T7: begin
                    if (state == last_step(op)) state <= stop ? HALTED : T0;
                    else                        state <= state_t'(state + 4'd1);
                end
                default: state <= HALTED;
            endcase
        end
    end

    always_comb begin
        run     = (state != RESET_ST) && (state != HALTED);
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        CONin   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        alu_sel = 5'b00000;
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3, T4, T5, T6, T7: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            T3: begin
                                Grb  = 1'b1;
                                Rout = 1'b1;
                                Yin  = 1'b1;
                            end
                            T4: begin
                                Zin = 1'b1;
                                // Immediate forms take the operand from the IR constant field.
                                if (op[3]) begin
                                    Cout    = 1'b1;
                                    alu_sel = imm_alu(op);
                                end else begin
                                    Grc     = 1'b1;
                                    Rout    = 1'b1;
                                    alu_sel = op;
                                end
                            end
                            T5: begin
                                Zlowout = 1'b1;
                                Gra     = 1'b1;
                                Rin     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        case (state)
                            T3: begin
                                Grb   = 1'b1;
                                BAout = 1'b1;
                                Yin   = 1'b1;
                            end
                            T4: begin
                                Cout    = 1'b1;
                                Zin     = 1'b1;
                                alu_sel = ADD_SEL;
                            end
                            T5: begin
                                Zlowout = 1'b1;
                                if (op == OP_LDI) begin
                                    Gra = 1'b1;
                                    Rin = 1'b1;
                                end else begin
                                    MARin = 1'b1;
                                end
                            end
                            T6: begin
                                MDRin = 1'b1;
                                if (op == OP_LD) begin
                                    Read = 1'b1;
                                end else begin
                                    Gra  = 1'b1;
                                    Rout = 1'b1;
                                end
                            end
                            T7: begin
                                if (op == OP_LD) begin
                                    MDRout = 1'b1;
                                    Gra    = 1'b1;
                                    Rin    = 1'b1;
                                end else begin
                                    Write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            T3: begin
                                Gra   = 1'b1;
                                Rout  = 1'b1;
                                CONin = 1'b1;
                            end
                            T4: begin
                                PCout = 1'b1;
                                Yin   = 1'b1;
                            end
                            T5: begin
                                Cout    = 1'b1;
                                Zin     = 1'b1;
                                alu_sel = ADD_SEL;
                            end
                            T6: begin
                                Zlowout = con_ff;
                                PCin    = con_ff;
                            end
                            default: ;
                        endcase
                    end
                    OP_JR: begin
                        if (state == T3) begin
                            Gra  = 1'b1;
                            Rout = 1'b1;
                            PCin = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
